vga_frame_bridge: RTL and testbench
===================================

Name: vga_frame_bridge

Overview:
CPU-side responder for the display's end-of-frame interrupt handshake. It holds CPU-writable shadow copies of the spaceship and planet positions and copies them to the position inputs of the VGA sync block only during the frame-boundary window. It also answers the display's frame-interrupt request and forwards a maskable interrupt to the CPU. It sits between the CPU memory-mapped I/O decode and the VGA sync generator.

Parameters:
DATA_W, 16, width of position registers and the CPU data bus.
ACK_TIMEOUT, 16, maximum clk cycles that vga_ack is held while waiting for vga_int to drop (minimum 4).

Ports:
clk  in  1  system clock; the same clock as the VGA sync block.
rst_n  in  1  asynchronous, active-low reset.
cpu_addr  in  3  register index.
cpu_we  in  1  write strobe; one write per cycle.
cpu_wdata  in  DATA_W  write data.
cpu_rdata  out  DATA_W  combinational read data for cpu_addr.
cpu_irq  out  1  level interrupt to the CPU.
vga_int  in  1  frame-end request from the VGA sync block.
vga_ack  out  1  acknowledge to the VGA sync block.
spaceship_x, spaceship_y  out  DATA_W  active spaceship position.
planet_x, planet_y  out  DATA_W  active planet position.

Behaviour:
- Single clock. rst_n is asynchronous, active-low.
- Reset values: vga_ack=0, cpu_irq=0, all four active and shadow positions=0, commit_pending=0, irq_en=0, irq_flag=0, overrun=0, frame_cnt=0, FSM=IDLE, timeout counter=0.
- Register map:
  - 0 SHIP_X shadow (RW). 1 SHIP_Y shadow (RW). 2 PLANET_X shadow (RW). 3 PLANET_Y shadow (RW).
  - 4 CTRL: bit0 commit_pending (write 1 arms it; write 0 has no effect; reads the current state). bit1 irq_en (RW).
  - 5 STATUS: bit0 irq_flag, bit1 overrun. Both are write-1-to-clear.
  - 6 FRAME_CNT (RO, wraps from 0xFFFF to 0).
  - 7 reads 0; writes are ignored.
  - Unused bits read 0.
- cpu_irq = irq_flag & irq_en, registered.
- FSM states:
  - IDLE: on vga_int=1, go to ACK. In that same edge:
    - if commit_pending=1, copy all four shadows to the active outputs and clear commit_pending;
    - if irq_flag is already 1, set overrun;
    - set irq_flag;
    - increment frame_cnt;
    - assert vga_ack=1 and clear the timeout counter.
  - ACK: hold vga_ack=1 and increment the timeout counter.
    - If vga_int=0, go to RELEASE with vga_ack=0.
    - If the counter reaches ACK_TIMEOUT-1 and vga_int is still 1, go to RELEASE with vga_ack=0 and set overrun.
  - RELEASE: vga_ack=0 for one cycle, then go to IDLE. This guarantees a deasserted gap of at least one cycle.
- Latency:
  - vga_int to vga_ack: 1 cycle.
  - vga_int to updated position outputs: 1 cycle.
  - vga_int to cpu_irq: 2 cycles.
  - The VGA side samples vga_ack only on its pixel tick (every 2 clk), so vga_ack is held until vga_int is observed low.
- A level vga_int that stays high after a timeout re-enters ACK only after passing through RELEASE and IDLE. Each entry counts as a new frame.
- Commit uses the shadow values registered before the edge. A CPU shadow write in the commit cycle lands in the shadow only and applies at the next commit.
- CPU arming commit_pending in the same cycle as the commit: set wins, so pending stays 1.
- STATUS W1C of irq_flag or overrun in the same cycle as a hardware set: set wins.
- Active position outputs change only in the IDLE-to-ACK transition. They never change mid-frame.
- Reset asserted mid-ACK: vga_ack drops immediately (asynchronously) and all state returns to reset values.

Decomposition:
- Shared package vga_pkg:
  - register index constants REG_SHIP_X..REG_FRAME_CNT;
  - CTRL/STATUS bit positions;
  - FSM enum with states IDLE, ACK, RELEASE;
  - typedef pos_t = logic [DATA_W-1:0].
- One sub-module: vga_ack_fsm (the handshake FSM plus the timeout counter). It outputs a one-cycle frame_start pulse used for commit, irq_flag and frame_cnt updates.
- The register file stays in the top module.

Test Plan:
1. Write SHIP_X=100, SHIP_Y=200 and CTRL=1, then pulse vga_int high for 4 cycles -> vga_ack=1 the next cycle. spaceship_x=100 and spaceship_y=200 the same cycle. commit_pending reads 0 afterwards. FRAME_CNT=1.
2. Write PLANET_X=50 without arming commit, then send a vga_int frame -> planet_x stays 0. Arm commit and send the next frame -> planet_x=50.
3. Write CTRL=2 (irq_en), send one frame -> cpu_irq=1 two cycles after vga_int. Write STATUS=1 -> cpu_irq=0 next cycle. Send two frames without clearing -> STATUS reads 3 (overrun set).
4. Hold vga_int=1 for 40 cycles with ACK_TIMEOUT=16 -> vga_ack high for exactly 16 cycles, then low for at least 1 cycle. overrun=1. Re-acknowledge while vga_int stays high.
5. Write SHIP_X=7 in the same cycle the commit fires (shadow previously 3) -> spaceship_x=3. The next armed frame gives 7.
6. Assert rst_n=0 during ACK -> vga_ack=0 immediately. All registers read 0 and the FSM is in IDLE after release.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame bridge: register map, bit positions, FSM states.
package vga_pkg;

  localparam int unsigned POS_W = 16;
  typedef logic [POS_W-1:0] pos_t;

  localparam logic [2:0] REG_SHIP_X    = 3'd0;
  localparam logic [2:0] REG_SHIP_Y    = 3'd1;
  localparam logic [2:0] REG_PLANET_X  = 3'd2;
  localparam logic [2:0] REG_PLANET_Y  = 3'd3;
  localparam logic [2:0] REG_CTRL      = 3'd4;
  localparam logic [2:0] REG_STATUS    = 3'd5;
  localparam logic [2:0] REG_FRAME_CNT = 3'd6;

  localparam int unsigned CTRL_COMMIT_BIT = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned STAT_IRQ_BIT    = 0;
  localparam int unsigned STAT_OVR_BIT    = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK     = 2'd1,
    RELEASE = 2'd2
  } ack_state_t;

endpackage

// File: rtl/vga_ack_fsm.sv
// Frame-interrupt handshake: acknowledges vga_int, times out a stuck request,
// and guarantees a deasserted ack gap before the next frame is accepted.
module vga_ack_fsm
  import vga_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic vga_int,
  output logic vga_ack,
  output logic frame_start,
  output logic ack_timeout
);

  localparam int unsigned     CNT_W   = $clog2(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ack_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Timeout counter: zero while idle so every ACK entry starts from 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt <= '0;
    else if (state == IDLE)  cnt <= '0;
    else if (state == ACK)   cnt <= cnt + CNT_ONE;
  end

  // Next-state logic plus the single-cycle event strobes
  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    ack_timeout = 1'b0;
    unique case (state)
      IDLE: begin
        if (vga_int) begin
          state_nxt   = ACK;
          frame_start = 1'b1;
        end
      end
      ACK: begin
        if (!vga_int) begin
          state_nxt = RELEASE;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = RELEASE;
          ack_timeout = 1'b1;
        end
      end
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack is a pure decode of the state register, so reset drops it asynchronously
  assign vga_ack = (state == ACK);

endmodule

// File: rtl/vga_frame_bridge.sv
// CPU-side bridge: shadow position registers committed to the VGA sync block at
// frame start, frame counter, and maskable frame interrupt to the CPU.
module vga_frame_bridge
  import vga_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        cpu_addr,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_irq,
  input  logic              vga_int,
  output logic              vga_ack,
  output logic [DATA_W-1:0] spaceship_x,
  output logic [DATA_W-1:0] spaceship_y,
  output logic [DATA_W-1:0] planet_x,
  output logic [DATA_W-1:0] planet_y
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic [DATA_W-1:0] sh_ship_x, sh_ship_y, sh_planet_x, sh_planet_y;
  logic [DATA_W-1:0] frame_cnt;
  logic              commit_pending, irq_en, irq_flag, overrun;
  logic              frame_start, ack_timeout;
  logic              we_ctrl, we_status;

  assign we_ctrl   = cpu_we && (cpu_addr == REG_CTRL);
  assign we_status = cpu_we && (cpu_addr == REG_STATUS);

  vga_ack_fsm #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_ack_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .vga_int    (vga_int),
    .vga_ack    (vga_ack),
    .frame_start(frame_start),
    .ack_timeout(ack_timeout)
  );

  // Shadow position registers, CPU-written at any time
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_ship_x   <= '0;
      sh_ship_y   <= '0;
      sh_planet_x <= '0;
      sh_planet_y <= '0;
    end else if (cpu_we) begin
      case (cpu_addr)
        REG_SHIP_X:   sh_ship_x   <= cpu_wdata;
        REG_SHIP_Y:   sh_ship_y   <= cpu_wdata;
        REG_PLANET_X: sh_planet_x <= cpu_wdata;
        REG_PLANET_Y: sh_planet_y <= cpu_wdata;
        default: ;
      endcase
    end
  end

  // Active positions update only on the IDLE-to-ACK edge, using pre-edge shadows
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spaceship_x <= '0;
      spaceship_y <= '0;
      planet_x    <= '0;
      planet_y    <= '0;
    end else if (frame_start && commit_pending) begin
      spaceship_x <= sh_ship_x;
      spaceship_y <= sh_ship_y;
      planet_x    <= sh_planet_x;
      planet_y    <= sh_planet_y;
    end
  end

  // Control/status flags; the hardware/CPU set is written last so set wins over clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
      irq_en         <= 1'b0;
      irq_flag       <= 1'b0;
      overrun        <= 1'b0;
      frame_cnt      <= '0;
      cpu_irq        <= 1'b0;
    end else begin
      if (frame_start)                             commit_pending <= 1'b0;
      if (we_ctrl && cpu_wdata[CTRL_COMMIT_BIT])   commit_pending <= 1'b1;
      if (we_ctrl)                                 irq_en <= cpu_wdata[CTRL_IRQ_EN_BIT];
      if (we_status && cpu_wdata[STAT_IRQ_BIT])    irq_flag <= 1'b0;
      if (frame_start)                             irq_flag <= 1'b1;
      if (we_status && cpu_wdata[STAT_OVR_BIT])    overrun <= 1'b0;
      if ((frame_start && irq_flag) || ack_timeout) overrun <= 1'b1;
      if (frame_start)                             frame_cnt <= frame_cnt + ONE;
      cpu_irq <= irq_flag && irq_en;
    end
  end

  // Combinational read mux; unused bits and address 7 read zero
  always_comb begin
    cpu_rdata = '0;
    case (cpu_addr)
      REG_SHIP_X:    cpu_rdata = sh_ship_x;
      REG_SHIP_Y:    cpu_rdata = sh_ship_y;
      REG_PLANET_X:  cpu_rdata = sh_planet_x;
      REG_PLANET_Y:  cpu_rdata = sh_planet_y;
      REG_CTRL: begin
        cpu_rdata[CTRL_COMMIT_BIT] = commit_pending;
        cpu_rdata[CTRL_IRQ_EN_BIT] = irq_en;
      end
      REG_STATUS: begin
        cpu_rdata[STAT_IRQ_BIT] = irq_flag;
        cpu_rdata[STAT_OVR_BIT] = overrun;
      end
      REG_FRAME_CNT: cpu_rdata = frame_cnt;
      default:       cpu_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_vga_frame_bridge.sv
// Directed self-checking bench for vga_frame_bridge.
module tb_vga_frame_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cpu_addr;
  logic        cpu_we;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_irq;
  logic        vga_int;
  logic        vga_ack;
  logic [15:0] spaceship_x, spaceship_y, planet_x, planet_y;

  int total = 0;
  int bad   = 0;

  vga_frame_bridge #(
    .DATA_W     (16),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_addr   (cpu_addr),
    .cpu_we     (cpu_we),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_irq    (cpu_irq),
    .vga_int    (vga_int),
    .vga_ack    (vga_ack),
    .spaceship_x(spaceship_x),
    .spaceship_y(spaceship_y),
    .planet_x   (planet_x),
    .planet_y   (planet_y)
  );

  always #50 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_we    = 1'b1;
    tick();
    cpu_we    = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    cpu_addr = a;
    #1;
    d = cpu_rdata;
  endtask

  // One-cycle frame request, then settle back to IDLE
  task automatic frame();
    vga_int = 1'b1;
    tick();
    vga_int = 1'b0;
    tick();
    tick();
    tick();
  endtask

  logic [15:0] d;
  logic [15:0] st16;
  logic        ack_hist [40];
  int          hi, lo;

  initial begin
    rst_n = 1'b0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0; vga_int = 1'b0;
    tick(); tick();
    chk("rst_ack", 16'(vga_ack), 16'd0);
    chk("rst_irq", 16'(cpu_irq), 16'd0);
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("rst_reg%0d", a), d, 16'd0);
    end
    chk("rst_sx", spaceship_x, 16'd0);

    // 1: commit on first frame
    wr(3'd0, 16'd100);
    wr(3'd1, 16'd200);
    wr(3'd4, 16'd1);
    rd(3'd4, d); chk("t1_ctrl_armed", d, 16'd1);
    vga_int = 1'b1;
    tick();
    chk("t1_ack", 16'(vga_ack), 16'd1);
    chk("t1_sx", spaceship_x, 16'd100);
    chk("t1_sy", spaceship_y, 16'd200);
    tick(); tick(); tick();
    chk("t1_ack_held", 16'(vga_ack), 16'd1);
    vga_int = 1'b0;
    tick();
    chk("t1_ack_drop", 16'(vga_ack), 16'd0);
    tick();
    rd(3'd4, d); chk("t1_ctrl_clr", d, 16'd0);
    rd(3'd6, d); chk("t1_fcnt", d, 16'd1);
    rd(3'd5, d); chk("t1_status", d, 16'd1);

    // 2: unarmed frame leaves position, armed frame applies it
    wr(3'd2, 16'd50);
    frame();
    chk("t2_px_unarmed", planet_x, 16'd0);
    wr(3'd4, 16'd1);
    frame();
    chk("t2_px_armed", planet_x, 16'd50);
    rd(3'd6, d); chk("t2_fcnt", d, 16'd3);

    // 3: interrupt path
    wr(3'd5, 16'd3);
    rd(3'd5, d); chk("t3_status_clr", d, 16'd0);
    wr(3'd4, 16'd2);
    vga_int = 1'b1;
    tick();
    chk("t3_irq_c1", 16'(cpu_irq), 16'd0);
    tick();
    chk("t3_irq_c2", 16'(cpu_irq), 16'd1);
    vga_int = 1'b0;
    tick(); tick();
    wr(3'd5, 16'd1);
    rd(3'd5, d); chk("t3_flag_w1c", d, 16'd0);
    tick();
    chk("t3_irq_off", 16'(cpu_irq), 16'd0);
    frame();
    frame();
    rd(3'd5, d); chk("t3_overrun", d, 16'd3);
    chk("t3_irq_on", 16'(cpu_irq), 16'd1);

    // 4: stuck request times out and re-acknowledges
    wr(3'd5, 16'd3);
    st16 = '0;
    vga_int = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      ack_hist[i] = vga_ack;
      if (i == 16) rd(3'd5, st16);
    end
    vga_int = 1'b0;
    tick(); tick(); tick();
    hi = 0;
    while (hi < 40 && ack_hist[hi]) hi++;
    lo = 0;
    while (hi + lo < 40 && !ack_hist[hi + lo]) lo++;
    chk("t4_high_len", 16'(hi), 16'd16);
    chk("t4_gap", 16'(lo >= 1), 16'd1);
    chk("t4_reack", 16'((hi + lo < 40) ? ack_hist[hi + lo] : 1'b0), 16'd1);
    chk("t4_status_at_timeout", st16, 16'd3);
    rd(3'd6, d); chk("t4_fcnt", d, 16'd9);

    // 5: shadow write during commit cycle lands in shadow only
    wr(3'd0, 16'd3);
    wr(3'd4, 16'd1);
    cpu_addr = 3'd0; cpu_wdata = 16'd7; cpu_we = 1'b1; vga_int = 1'b1;
    tick();
    cpu_we = 1'b0;
    chk("t5_sx_old", spaceship_x, 16'd3);
    vga_int = 1'b0;
    tick(); tick();
    rd(3'd0, d); chk("t5_shadow", d, 16'd7);
    wr(3'd4, 16'd1);
    frame();
    chk("t5_sx_new", spaceship_x, 16'd7);
    // arming in the commit cycle: set wins
    wr(3'd1, 16'd9);
    wr(3'd4, 16'd1);
    cpu_addr = 3'd4; cpu_wdata = 16'd1; cpu_we = 1'b1; vga_int = 1'b1;
    tick();
    cpu_we = 1'b0;
    chk("t5_sy_commit", spaceship_y, 16'd9);
    vga_int = 1'b0;
    tick(); tick();
    rd(3'd4, d); chk("t5_pending_kept", d, 16'd1);
    // STATUS W1C coinciding with hardware set: set wins
    cpu_addr = 3'd5; cpu_wdata = 16'd3; cpu_we = 1'b1; vga_int = 1'b1;
    tick();
    cpu_we = 1'b0;
    vga_int = 1'b0;
    tick(); tick();
    rd(3'd5, d); chk("t5_w1c_setwins", d, 16'd3);
    rd(3'd6, d); chk("t5_fcnt", d, 16'd13);

    // 6: asynchronous reset during ACK
    vga_int = 1'b1;
    tick();
    chk("t6_ack_before", 16'(vga_ack), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_ack_async", 16'(vga_ack), 16'd0);
    chk("t6_sx", spaceship_x, 16'd0);
    chk("t6_py", planet_x, 16'd0);
    vga_int = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), d);
      chk($sformatf("t6_reg%0d", a), d, 16'd0);
    end
    vga_int = 1'b1;
    tick();
    chk("t6_idle_ack", 16'(vga_ack), 16'd1);
    rd(3'd6, d); chk("t6_fcnt", d, 16'd1);
    vga_int = 1'b0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
